ram_io_responder: RTL and testbench

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

---
 rtl/ram_io_responder_pkg.sv | 29 ++
 rtl/ram_io_responder_fifo.sv | 57 +++++
 rtl/ram_io_responder.sv | 103 ++++++++++
 tb/tb_ram_io_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared constants and helpers for the RAM/IO responder.
// Address map for the memory-mapped TX port and status register.
package ram_io_responder_pkg;

    localparam logic [1:0]  IO_REGION    = 2'b11;
    localparam logic [31:0] IO_TX_ADDR   = 32'h0003_0000;
    localparam logic [31:0] IO_STAT_ADDR = 32'h0003_0004;

    typedef enum logic [1:0] {
        ACC_RAM_RD,
        ACC_RAM_WR,
        ACC_IO_RD,
        ACC_IO_WR
    } acc_e;

    function automatic acc_e classify(input logic rw, input logic io);
        case ({io, rw})
            2'b00:   return ACC_RAM_RD;
            2'b01:   return ACC_RAM_WR;
            2'b10:   return ACC_IO_RD;
            default: return ACC_IO_WR;
        endcase
    endfunction

    function automatic logic [7:0] status_byte(input logic ovf, input logic full);
        return {6'b0, ovf, full};
    endfunction

endpackage

// File: rtl/ram_io_responder_fifo.sv
// byte_fifo: power-of-two byte queue with count, full and empty flags.
// Head byte is presented combinationally; pointers wrap naturally.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               data_i,
    output logic [7:0]               data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];

    // A push into a full queue is only legal when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d    = do_push ? wr_q + PW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !reset) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM responder with optional memory-mapped TX FIFO and status.
// The IO region, FIFO and status register exist only with RAM_RESP_IO_EN.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ram_rw,
    input  logic [31:0] ram_addr,
    input  logic [7:0]  ram_w_data,
    output logic [7:0]  ram_r_data,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready,
    output logic        io_full
);

    logic [7:0]            mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  io_sel;
    logic [7:0]            io_rd;
    logic [7:0]            r_data_q, r_data_d;
    acc_e                  acc;

    assign idx = ram_addr[ADDR_WIDTH-1:0];
    assign acc = classify(ram_rw, io_sel);

`ifdef RAM_RESP_IO_EN
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          tx_wr, stat_wr, stat_rd;
    logic          push, pop, ovf_set;
    logic          empty;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] unused_count;

    assign io_sel  = (ram_addr[17:16] == IO_REGION);
    assign tx_wr   = (acc == ACC_IO_WR) && (ram_addr == IO_TX_ADDR);
    assign stat_wr = (acc == ACC_IO_WR) && (ram_addr == IO_STAT_ADDR);
    assign stat_rd = (acc == ACC_IO_RD) && (ram_addr == IO_STAT_ADDR);

    assign io_tx_valid = !empty;
    assign pop     = io_tx_valid && io_tx_ready;
    assign push    = tx_wr && (!io_full || pop);
    assign ovf_set = tx_wr && io_full && !pop;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ram_w_data),
        .data_o  (io_tx_data),
        .count_o (unused_count),
        .full_o  (io_full),
        .empty_o (empty)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (stat_wr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign io_rd = stat_rd ? status_byte(ovf_q, io_full) : 8'h00;
`else
    logic unused_in;

    assign io_sel      = 1'b0;
    assign io_rd       = 8'h00;
    assign io_tx_data  = 8'h00;
    assign io_tx_valid = 1'b0;
    assign io_full     = 1'b0;
    assign unused_in   = ^{ram_addr[31:ADDR_WIDTH], io_tx_ready};
`endif

    always_ff @(posedge clock) begin
        if (!reset && acc == ACC_RAM_WR) mem[idx] <= ram_w_data;
    end

    always_comb begin
        r_data_d = io_sel ? io_rd : mem[idx];
    end

    always_ff @(posedge clock) begin
        if (reset) r_data_q <= 8'h00;
        else       r_data_q <= r_data_d;
    end

    assign ram_r_data = r_data_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed vector bench for ram_io_responder; follows the IO build
// when RAM_RESP_IO_EN is defined, otherwise the RAM-only build.
module tb_ram_io_responder;

    localparam logic [31:0] TX   = 32'h0003_0000;
    localparam logic [31:0] STAT = 32'h0003_0004;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ram_rw = 1'b0;
    logic [31:0] ram_addr = '0;
    logic [7:0]  ram_w_data = '0;
    logic [7:0]  ram_r_data;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready = 1'b0;
    logic        io_full;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [7:0]  wd;
        logic        rdy;
        logic        crd;
        logic [7:0]  erd;
        logic        cio;
        logic        evld;
        logic        efull;
        logic        cdat;
        logic [7:0]  edat;
    } vec_t;

    vec_t tbl[$];

    ram_io_responder dut (
        .clock       (clock),
        .reset       (reset),
        .ram_rw      (ram_rw),
        .ram_addr    (ram_addr),
        .ram_w_data  (ram_w_data),
        .ram_r_data  (ram_r_data),
        .io_tx_data  (io_tx_data),
        .io_tx_valid (io_tx_valid),
        .io_tx_ready (io_tx_ready),
        .io_full     (io_full)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(
        logic rw, logic [31:0] addr, logic [7:0] wd, logic rdy,
        logic crd, logic [7:0] erd,
        logic cio, logic evld, logic efull,
        logic cdat, logic [7:0] edat);
        vec_t v;
        v.rw = rw; v.addr = addr; v.wd = wd; v.rdy = rdy;
        v.crd = crd; v.erd = erd;
        v.cio = cio; v.evld = evld; v.efull = efull;
        v.cdat = cdat; v.edat = edat;
        return v;
    endfunction

    task automatic chk(string nm, int i, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %h, want %h", nm, i, act, exp);
        end
    endtask

    task automatic apply(vec_t v, int i);
        ram_rw      = v.rw;
        ram_addr    = v.addr;
        ram_w_data  = v.wd;
        io_tx_ready = v.rdy;
        @(posedge clock);
        #1;
        if (v.crd) chk("r_data", i, ram_r_data, v.erd);
        if (v.cio) begin
            chk("tx_valid", i, {7'b0, io_tx_valid}, {7'b0, v.evld});
            chk("full", i, {7'b0, io_full}, {7'b0, v.efull});
        end
        if (v.cdat) chk("tx_data", i, io_tx_data, v.edat);
    endtask

    initial begin
        // Common RAM rows: basic read-back, aliasing, read-first.
        tbl.push_back(mk(1, 32'h1234, 8'hA5, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h1234, 8'h00, 0, 1, 8'hA5, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h0010, 8'h11, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h10010, 8'h22, 0, 1, 8'h11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0010, 8'h00, 0, 1, 8'h22, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h0020, 8'h5A, 0, 0, 0, 1, 0, 0, 0, 0));
`ifdef RAM_RESP_IO_EN
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(1, TX, 8'(k), 0, 0, 0,
                             1, 1, k >= 8, 1, 8'h01));
        tbl.push_back(mk(0, STAT, 8'h00, 0, 1, 8'h03, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, STAT, 8'hFF, 0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, STAT, 8'h00, 0, 1, 8'h01, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, TX, 8'h55, 1, 0, 0, 1, 1, 1, 1, 8'h02));
        tbl.push_back(mk(0, STAT, 8'h00, 0, 1, 8'h01, 1, 1, 1, 1, 8'h02));
        // Drain 2..8 then 0x55 while idly polling the status register.
        for (int n = 1; n <= 8; n++)
            tbl.push_back(mk(0, STAT, 8'h00, 1,
                             1, (n == 1) ? 8'h01 : 8'h00,
                             1, n < 8, 0,
                             n < 8, (n == 7) ? 8'h55 : 8'(n + 2)));
        tbl.push_back(mk(1, TX, 8'h77, 1, 0, 0, 1, 1, 0, 1, 8'h77));
        tbl.push_back(mk(0, 32'h0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h30008, 8'hEE, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h30008, 8'h00, 0, 1, 8'h00, 1, 0, 0, 0, 0));
`else
        tbl.push_back(mk(1, TX, 8'h7E, 1, 0, 0, 1, 0, 0, 1, 8'h00));
        tbl.push_back(mk(0, TX, 8'h00, 1, 1, 8'h7E, 1, 0, 0, 1, 8'h00));
        tbl.push_back(mk(0, STAT, 8'h00, 0, 0, 0, 1, 0, 0, 1, 8'h00));
`endif

        repeat (2) @(posedge clock);
        #1;
        chk("rst r_data", 0, ram_r_data, 8'h00);
        chk("rst valid", 0, {7'b0, io_tx_valid}, 8'h00);
        chk("rst full", 0, {7'b0, io_full}, 8'h00);
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i], i + 1);

        // Queue three bytes, then reset while another push is offered.
        for (int k = 0; k < 3; k++)
            apply(mk(1, TX, 8'hC0 + 8'(k), 0, 0, 0, 0, 0, 0, 0, 0), 100 + k);
`ifdef RAM_RESP_IO_EN
        chk("pre-rst valid", 103, {7'b0, io_tx_valid}, 8'h01);
`endif
        reset      = 1'b1;
        ram_rw     = 1'b1;
        ram_addr   = TX;
        ram_w_data = 8'h99;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        ram_rw = 1'b0;
        chk("post-rst valid", 104, {7'b0, io_tx_valid}, 8'h00);
        chk("post-rst full", 104, {7'b0, io_full}, 8'h00);
        chk("post-rst r_data", 104, ram_r_data, 8'h00);
        apply(mk(0, STAT, 8'h00, 0, 1, 8'h00, 1, 0, 0, 0, 0), 105);
        apply(mk(0, 32'h0020, 8'h00, 0, 1, 8'h5A, 1, 0, 0, 0, 0), 106);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
